// File: rtl/goomy_pkg.sv
// ----------------------------------------------------------------------------
// goomy_pkg
// Shared types and widths for the stor_mem word store and its write queue.
//   MEM_ADDR_W : word address width (addresses are [MEM_ADDR_W:1])
//   MEM_DATA_W : word data width
//   wq_entry_t : one queued store {addr, data}
// ----------------------------------------------------------------------------
package goomy_pkg;

    localparam int MEM_ADDR_W = 15;
    localparam int MEM_DATA_W = 16;

    typedef logic [MEM_ADDR_W:1]   mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

    typedef struct packed {
        mem_addr_t addr;
        mem_data_t data;
    } wq_entry_t;

endpackage

// File: rtl/stor_mem_wq_if.sv
// ----------------------------------------------------------------------------
// stor_mem_wq_if
// Store request handshake from the execute side into the write queue.
//   st_valid : store request
//   st_ready : queue can accept a store this cycle
//   st_addr  : store word address
//   st_data  : store data
// master = store producer, slave = write queue.
// ----------------------------------------------------------------------------
interface stor_mem_wq_if;
    import goomy_pkg::*;

    logic      st_valid;
    logic      st_ready;
    mem_addr_t st_addr;
    mem_data_t st_data;

    modport master (output st_valid, output st_addr, output st_data, input st_ready);
    modport slave  (input st_valid, input st_addr, input st_data, output st_ready);

endinterface

// File: rtl/wq_fwd_match.sv
// ----------------------------------------------------------------------------
// wq_fwd_match
// Combinational youngest-match search over the write queue entries.
//   entries : entry array (circular buffer storage)
//   head    : index of the oldest valid entry
//   count   : number of valid entries, 0..DEPTH
//   ld_addr : load word address to look up
//   hit     : some valid entry matches ld_addr
//   data    : data of the youngest matching entry (0 when no hit)
// ----------------------------------------------------------------------------
module wq_fwd_match
    import goomy_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  wq_entry_t            entries [DEPTH],
    input  logic [PTR_BITS-1:0]  head,
    input  logic [PTR_BITS:0]    count,
    input  mem_addr_t            ld_addr,
    output logic                 hit,
    output mem_data_t            data
);

    logic [PTR_BITS-1:0] idx;

    // Walk from oldest to youngest; a later match overwrites an earlier one,
    // so the youngest matching store is what remains.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip an assignment would infer a latch.
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_BITS'(i);
            if (((PTR_BITS+1)'(i) < count) && (entries[idx].addr == ld_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/stor_mem_wq.sv
// ----------------------------------------------------------------------------
// stor_mem_wq
// Write queue and port controller for stor_mem. Buffers stores, drains one per
// cycle into the stor_mem write port, and serves loads on read port 1 with
// forwarding from queued stores.
//   clk, rst_n           : clock, asynchronous active-low reset
//   st (slave)           : store handshake (st_valid/st_ready/st_addr/st_data)
//   ld_addr / ld_data    : combinational load lookup
//   drain_en             : 0 holds draining (enqueue still allowed)
//   empty                : no entries queued
//   mem_wen/waddr/wdata  : stor_mem write port
//   mem_raddr1/rdata1    : stor_mem read port 1
// ----------------------------------------------------------------------------
module stor_mem_wq
    import goomy_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    stor_mem_wq_if.slave      st,
    input  mem_addr_t         ld_addr,
    output mem_data_t         ld_data,
    input  logic              drain_en,
    output logic              empty,
    output logic              mem_wen,
    output mem_addr_t         mem_waddr,
    output mem_data_t         mem_wdata,
    output mem_addr_t         mem_raddr1,
    input  mem_data_t         mem_rdata1
);

    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);

    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [PTR_BITS:0]   count_q, count_d;
    wq_entry_t           entries_q [DEPTH];

    logic      st_ready_w;
    logic      enq;
    logic      fwd_hit;
    mem_data_t fwd_data;

    // Ready depends only on registered count: no full-queue bypass, and no
    // combinational path from st_* to any output.
    assign st_ready_w  = (count_q != FULL_CNT);
    assign st.st_ready = st_ready_w;
    assign empty       = (count_q == '0);
    assign mem_wen     = drain_en && !empty;
    assign enq         = st.st_valid && st_ready_w;

    assign mem_waddr   = entries_q[head_q].addr;
    assign mem_wdata   = entries_q[head_q].data;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) tail_d = tail_q + 1'b1;
        if (mem_wen) head_d = head_q + 1'b1;
        unique case ({enq, mem_wen})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array is deliberately not reset; an entry is only ever
    // read while count marks it valid, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[tail_q] <= '{addr: st.st_addr, data: st.st_data};
        end
    end

    wq_fwd_match #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fwd (
        .entries (entries_q),
        .head    (head_q),
        .count   (count_q),
        .ld_addr (ld_addr),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    // The head entry being drained this cycle still forwards: memory only
    // takes the write at the coming edge.
    assign mem_raddr1 = ld_addr;
    assign ld_data    = fwd_hit ? fwd_data : mem_rdata1;

endmodule
